// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential shift-add multiplier / restoring divider, one bit per cycle.
// Optional feature macro: MULDIV_SIGNED_EN (two's complement operands via signed_op).
// Without the macro, signed_op is ignored and every operation is unsigned.
module muldiv_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mult,
  input  logic             div,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic            is_mul_q, is_mul_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dzf_q, dzf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Signed handling is compiled in only when the feature macro is present.
  logic sgn_en;
`ifdef MULDIV_SIGNED_EN
  assign sgn_en = signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn_en = 1'b0;
`endif

  // Operand signs and magnitudes captured at acceptance.
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sa    = sgn_en & op_a[WIDTH-1];
  assign sb    = sgn_en & op_b[WIDTH-1];
  assign a_mag = sa ? (WIDTH'(0) - op_a) : op_a;
  assign b_mag = sb ? (WIDTH'(0) - op_b) : op_b;

  // Multiply step: add multiplicand into upper half when multiplier LSB set, shift right.
  logic [WIDTH:0]  msum;
  logic [DW-1:0]   mul_nx;
  assign msum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
  assign mul_nx = {msum, acc_q[WIDTH-1:1]};

  // Divide step: shift remainder:quotient left, subtract divisor if it fits.
  logic [WIDTH:0]   dtop;
  logic             dge;
  logic [WIDTH-1:0] ddiff;
  logic [DW-1:0]    div_nx;
  assign dtop   = acc_q[DW-1:WIDTH-1];
  assign dge    = dtop >= {1'b0, opnd_q};
  assign ddiff  = dtop[WIDTH-1:0] - opnd_q;
  assign div_nx = {(dge ? ddiff : dtop[WIDTH-1:0]), acc_q[WIDTH-2:0], dge};

  // Sign-corrected result presented when the operation completes.
  logic [DW-1:0] res;
  always_comb begin
    res = acc_q;
    if (is_mul_q) begin
      res = neg_q ? (DW'(0) - acc_q) : acc_q;
    end else begin
      res[DW-1:WIDTH] = rneg_q ? (WIDTH'(0) - acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
      res[WIDTH-1:0]  = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0])  : acc_q[WIDTH-1:0];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dzf_d    = dzf_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start && (mult || div)) begin
          is_mul_d = mult;
          dzf_d    = 1'b0;
          cnt_d    = '0;
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          if (mult) begin
            opnd_d  = a_mag;
            acc_d   = {WIDTH'(0), b_mag};
            state_d = CALC;
          end else if (op_b == WIDTH'(0)) begin
            // Divide by zero bypasses iteration; raw dividend goes to hi.
            dzf_d   = 1'b1;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            opnd_d  = op_b;
            acc_d   = {op_a, {WIDTH{1'b1}}};
            state_d = DONE;
          end else begin
            opnd_d  = b_mag;
            acc_d   = {WIDTH'(0), a_mag};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = is_mul_q ? mul_nx : div_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dz_d    = dzf_q;
        hi_d    = res[DW-1:WIDTH];
        lo_d    = res[WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dzf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dzf_q    <= dzf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled each clk edge.
REQ-005 SHALL have port mult  input  1  decode flag: multiply requested.
REQ-006 SHALL have port div  input  1  decode flag: divide requested.
REQ-007 SHALL have port signed_op  input  1  treat operands as two's complement.
REQ-008 SHALL have port op_a  input  WIDTH  multiplicand / dividend.
REQ-009 SHALL have port op_b  input  WIDTH  multiplier / divisor.
REQ-010 SHALL have port busy  output  1  operation in progress; pipeline stall request.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port dz  output  1  last divide had divisor zero.
REQ-013 SHALL have port hi  output  WIDTH  product high half / remainder.
REQ-014 SHALL have port lo  output  WIDTH  product low half / quotient.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; encoding is implementer's choice.
REQ-016 In IDLE, start=1 with mult=1 or div=1 SHALL latch op_a, op_b, op kind, signed_op, clear dz, and go to CALC.
REQ-017 If mult=1 and div=1 together, multiply SHALL win; start with neither flag SHALL be ignored (stay IDLE).
REQ-018 Divide with op_b=0 SHALL skip CALC, go IDLE->DONE, set dz=1, lo=all ones, hi=op_a.
REQ-019 CALC SHALL run exactly WIDTH iterations (one per cycle, iteration counter 0..WIDTH-1), then go to DONE.
REQ-020 Multiply SHALL be shift-add over a 2*WIDTH accumulator; result {hi,lo} = op_a*op_b modulo 2^(2*WIDTH).
REQ-021 Divide SHALL be restoring shift-subtract; lo=quotient, hi=remainder.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; no start accepted in DONE.
REQ-023 Latency: start accepted at edge N SHALL give done=1 in cycle after edge N+WIDTH+1 (divide-by-zero: after edge N+1).
REQ-024 busy SHALL be 1 in CALC and DONE, 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored with no effect on state, operands or results.
REQ-026 hi, lo, dz SHALL update only in the cycle done rises and hold until the next accepted operation completes.
REQ-027 Operand inputs changing after acceptance SHALL not affect the result.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0.
REQ-029 Reset mid-CALC SHALL abort the operation with no done pulse; first start after release SHALL be accepted normally.

Configuration
REQ-030 With MULDIV_SIGNED_EN defined, signed_op=1 SHALL take magnitudes at acceptance and correct signs at DONE: product sign = XOR of signs, quotient truncates toward zero, remainder takes dividend sign; latency unchanged.
REQ-031 Without MULDIV_SIGNED_EN, signed_op SHALL be ignored and all operations unsigned.

Verification (WIDTH=16)
REQ-032 mult, a=3, b=5 -> done 17 cycles after accept, hi=0x0000, lo=0x000F, dz=0.
REQ-033 mult, a=0xFFFF, b=0xFFFF unsigned -> hi=0xFFFE, lo=0x0001.
REQ-034 div, a=100, b=7 -> lo=0x000E, hi=0x0002; second start pulsed mid-CALC -> ignored, single done.
REQ-035 div, a=5, b=0 -> done 1 cycle after accept, dz=1, lo=0xFFFF, hi=0x0005.
REQ-036 MULDIV_SIGNED_EN, div signed a=-7 (0xFFF9), b=2 -> lo=0xFFFD, hi=0xFFFF; without macro -> lo=0x7FFC, hi=0x0001.
REQ-037 rst_n low at CALC iteration 8 -> outputs zero immediately, no done; fresh mult 2*2 after release -> lo=0x0004.
